// File: rtl/header_buffer_ctrl.sv
// header_buffer_ctrl: pointer, occupancy and sequencing logic for a circular header block RAM
// Writes arrive one fixed-length frame at a time on port A. Frames are read out oldest-first on port B.
// Ports:
//   clock, global_reset             : rising-edge clock, asynchronous active-high reset
//   wr_start, wr_en, wr_data        : frame start pulse, word strobe and word from the header builder
//   rd_start                        : request readout of the oldest committed frame
//   rd_busy, rd_valid, rd_last      : readout in progress, word valid, final word of frame
//   rd_data                         : readout word (RAM port B data aligned to rd_valid)
//   ram_wea, ram_adra, ram_dataa    : RAM port A write strobe, address, data
//   ram_enb, ram_adrb, ram_datab    : RAM port B read enable, address, data (one-clock latency)
//   nframes, buf_full, buf_empty    : committed unclaimed frames, no room for a frame, nothing pending
//   wr_overflow, seq_err            : sticky refused-frame and protocol-violation flags
module header_buffer_ctrl #(
    parameter int RAM_WIDTH = 18,
    parameter int RAM_ADRB  = 11,
    parameter int HDR_WORDS = 42
) (
    input  logic                 clock,
    input  logic                 global_reset,
    input  logic                 wr_start,
    input  logic                 wr_en,
    input  logic [RAM_WIDTH-1:0] wr_data,
    input  logic                 rd_start,
    output logic                 rd_busy,
    output logic                 rd_valid,
    output logic                 rd_last,
    output logic [RAM_WIDTH-1:0] rd_data,
    output logic                 ram_wea,
    output logic [RAM_ADRB-1:0]  ram_adra,
    output logic [RAM_WIDTH-1:0] ram_dataa,
    output logic                 ram_enb,
    output logic [RAM_ADRB-1:0]  ram_adrb,
    input  logic [RAM_WIDTH-1:0] ram_datab,
    output logic [RAM_ADRB-1:0]  nframes,
    output logic                 buf_full,
    output logic                 buf_empty,
    output logic                 wr_overflow,
    output logic                 seq_err
);

    localparam logic [RAM_ADRB:0]   DEPTH = (RAM_ADRB+1)'(2**RAM_ADRB);
    localparam logic [RAM_ADRB:0]   HDR   = (RAM_ADRB+1)'(HDR_WORDS);
    localparam logic [RAM_ADRB-1:0] LASTW = RAM_ADRB'(HDR_WORDS-1);

    typedef enum logic {W_IDLE, W_FILL} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_READ, R_DRAIN} rstate_t;

    wstate_t               w_state, w_next;
    rstate_t               r_state, r_next;
    logic [RAM_ADRB-1:0]   wr_ptr, wr_cnt, rd_ptr, rd_cnt;
    logic [RAM_ADRB:0]     used_words;
    logic                  refused;
    logic                  accept, refuse, commit, seq_hit;
    logic                  claim, release_sp, rd_end;

    // Write side: space for a whole frame is reserved when the frame is accepted.
    always_comb begin
        ram_wea = (w_state == W_FILL) && wr_en;
        accept  = (w_state == W_IDLE) && wr_start && !buf_full;
        refuse  = (w_state == W_IDLE) && wr_start && buf_full;
        commit  = ram_wea && (wr_cnt == LASTW);
        // After a refusal the orphaned frame's words are silently dropped.
        seq_hit = ((w_state == W_FILL) && wr_start) ||
                  ((w_state == W_IDLE) && wr_en && !wr_start && !refused);
        w_next  = accept ? W_FILL : commit ? W_IDLE : w_state;
    end

    // Read side: words stay reserved until the last address has been issued.
    always_comb begin
        claim      = (r_state == R_IDLE) && rd_start && (nframes != '0);
        ram_enb    = (r_state == R_READ);
        rd_end     = ram_enb && (rd_cnt == LASTW);
        release_sp = (r_state == R_DRAIN);
        r_next     = claim ? R_READ : rd_end ? R_DRAIN : release_sp ? R_IDLE : r_state;
    end

    always_ff @(posedge clock or posedge global_reset) begin
        if (global_reset) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    always_ff @(posedge clock or posedge global_reset) begin
        if (global_reset) begin
            wr_ptr      <= '0;
            wr_cnt      <= '0;
            refused     <= 1'b0;
            wr_overflow <= 1'b0;
            seq_err     <= 1'b0;
        end else begin
            wr_ptr      <= ram_wea ? wr_ptr + 1'b1 : wr_ptr;
            wr_cnt      <= accept ? '0 : ram_wea ? wr_cnt + 1'b1 : wr_cnt;
            refused     <= refuse ? 1'b1 : accept ? 1'b0 : refused;
            wr_overflow <= wr_overflow | refuse;
            seq_err     <= seq_err | seq_hit;
        end
    end

    always_ff @(posedge clock or posedge global_reset) begin
        if (global_reset) begin
            rd_ptr   <= '0;
            rd_cnt   <= '0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
        end else begin
            rd_ptr   <= ram_enb ? rd_ptr + 1'b1 : rd_ptr;
            rd_cnt   <= claim ? '0 : ram_enb ? rd_cnt + 1'b1 : rd_cnt;
            rd_valid <= ram_enb;
            rd_last  <= rd_end;
        end
    end

    // Reserve and release in the same cycle cancel; so do commit and claim.
    always_ff @(posedge clock or posedge global_reset) begin
        if (global_reset) begin
            used_words <= '0;
            nframes    <= '0;
        end else begin
            used_words <= used_words + (accept ? HDR : '0) - (release_sp ? HDR : '0);
            nframes    <= nframes + RAM_ADRB'(commit) - RAM_ADRB'(claim);
        end
    end

    assign ram_adra  = wr_ptr;
    assign ram_dataa = ram_wea ? wr_data : '0;
    assign ram_adrb  = rd_ptr;
    assign rd_data   = rd_valid ? ram_datab : '0;
    assign rd_busy   = (r_state != R_IDLE);
    assign buf_full  = (DEPTH - used_words) < HDR;
    assign buf_empty = (nframes == '0) && !rd_busy;

endmodule

// File: tb/tb_header_buffer_ctrl.sv
// tb_header_buffer_ctrl: directed scoreboard bench for header_buffer_ctrl with a behavioural RAM
module tb_header_buffer_ctrl;

    localparam int W = 18;
    localparam int A = 11;
    localparam int H = 42;
    localparam int D = 2048;

    logic          clock = 1'b0;
    logic          global_reset = 1'b0;
    logic          wr_start = 1'b0, wr_en = 1'b0, rd_start = 1'b0;
    logic [W-1:0]  wr_data = '0;
    logic          rd_busy, rd_valid, rd_last, ram_wea, ram_enb;
    logic          buf_full, buf_empty, wr_overflow, seq_err;
    logic [W-1:0]  rd_data, ram_dataa, ram_datab;
    logic [A-1:0]  ram_adra, ram_adrb, nframes;
    logic [W-1:0]  mem [D];

    logic [W-1:0]  exp_q [$];
    int            vectors = 0, errors = 0;
    int            model_used = 0, model_nf = 0, model_wptr = 0, seq = 0;
    bit            model_ovf = 0, model_seq = 0;

    header_buffer_ctrl #(.RAM_WIDTH(W), .RAM_ADRB(A), .HDR_WORDS(H)) dut (
        .clock(clock), .global_reset(global_reset),
        .wr_start(wr_start), .wr_en(wr_en), .wr_data(wr_data),
        .rd_start(rd_start), .rd_busy(rd_busy), .rd_valid(rd_valid), .rd_last(rd_last),
        .rd_data(rd_data), .ram_wea(ram_wea), .ram_adra(ram_adra), .ram_dataa(ram_dataa),
        .ram_enb(ram_enb), .ram_adrb(ram_adrb), .ram_datab(ram_datab),
        .nframes(nframes), .buf_full(buf_full), .buf_empty(buf_empty),
        .wr_overflow(wr_overflow), .seq_err(seq_err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (ram_wea) mem[ram_adra] <= ram_dataa;
        if (ram_enb) ram_datab <= mem[ram_adrb];
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        #2 global_reset = 1'b1;
        #1;
        chk("rst_rd_busy", rd_busy, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_last", rd_last, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_ram_wea", ram_wea, 0);
        chk("rst_ram_adra", ram_adra, 0);
        chk("rst_ram_dataa", ram_dataa, 0);
        chk("rst_ram_enb", ram_enb, 0);
        chk("rst_ram_adrb", ram_adrb, 0);
        chk("rst_nframes", nframes, 0);
        chk("rst_buf_full", buf_full, 0);
        chk("rst_buf_empty", buf_empty, 1);
        chk("rst_wr_overflow", wr_overflow, 0);
        chk("rst_seq_err", seq_err, 0);
        wr_en = 1'b0;
        wr_start = 1'b0;
        rd_start = 1'b0;
        @(negedge clock);
        global_reset = 1'b0;
        exp_q.delete();
        model_used = 0;
        model_nf = 0;
        model_wptr = 0;
        model_ovf = 0;
        model_seq = 0;
    endtask

    task automatic write_frame(input int gap, input bit mid_start, input bit pre,
                               input bit rd_on_last, input int abort_at);
        bit acc;
        acc = (D - model_used) >= H;
        if (!pre) begin
            wr_start = 1'b1;
            @(negedge clock);
            wr_start = 1'b0;
        end
        if (acc) model_used += H;
        else model_ovf = 1;
        chk("wr_overflow", wr_overflow, model_ovf);
        for (int i = 0; i < H; i++) begin
            if (i == abort_at) begin
                do_reset();
                return;
            end
            wr_en = 1'b1;
            wr_data = W'(seq);
            if (mid_start && i == 20) wr_start = 1'b1;
            if (rd_on_last && i == H-1) rd_start = 1'b1;
            #1;
            chk("ram_wea", ram_wea, acc);
            if (acc) begin
                chk("ram_adra", ram_adra, model_wptr);
                exp_q.push_back(W'(seq));
                model_wptr = (model_wptr + 1) % D;
            end
            seq++;
            @(negedge clock);
            wr_en = 1'b0;
            wr_start = 1'b0;
            rd_start = 1'b0;
            if (i < H-1) repeat (gap) @(negedge clock);
        end
        if (acc && mid_start) model_seq = 1;
        if (acc) model_nf++;
        if (rd_on_last) model_nf--;
        chk("nframes", nframes, model_nf);
        chk("buf_full", buf_full, (D - model_used) < H);
        chk("seq_err", seq_err, model_seq);
    endtask

    task automatic read_collect(input bit started, input bit ws_on_last, input int abort_at);
        int cyc, beats;
        logic [W-1:0] ev;
        if (!started) begin
            rd_start = 1'b1;
            @(negedge clock);
            rd_start = 1'b0;
            model_nf--;
        end
        chk("rd_busy_start", rd_busy, 1);
        chk("nframes_claim", nframes, model_nf);
        cyc = 1;
        beats = 0;
        while (beats < H && cyc < 100) begin
            if (rd_valid) begin
                if (beats == abort_at) begin
                    do_reset();
                    return;
                end
                if (beats == 0) chk("rd_latency", cyc, 2);
                ev = exp_q.size() > 0 ? exp_q.pop_front() : W'(18'h3dead);
                chk("rd_data", rd_data, ev);
                chk("rd_last", rd_last, beats == H-1);
                if (beats == H-1 && ws_on_last) wr_start = 1'b1;
                beats++;
            end
            @(negedge clock);
            cyc++;
        end
        wr_start = 1'b0;
        chk("rd_beats", beats, H);
        chk("rd_busy_end", rd_busy, 0);
        model_used -= H;
        chk("buf_empty", buf_empty, model_nf == 0);
    endtask

    initial begin
        @(negedge clock);
        do_reset();

        write_frame(0, 0, 0, 0, -1);
        read_collect(0, 0, -1);

        repeat (48) write_frame(0, 0, 0, 0, -1);
        chk("nframes_48", nframes, 48);
        chk("full_48", buf_full, 1);
        write_frame(0, 0, 0, 0, -1);
        chk("ovf_set", wr_overflow, 1);
        chk("nframes_after_refuse", nframes, 48);

        repeat (48) read_collect(0, 0, -1);
        repeat (100) begin
            write_frame(0, 0, 0, 0, -1);
            read_collect(0, 0, -1);
        end

        chk("seq_err_clear", seq_err, 0);
        write_frame(10, 1, 0, 0, -1);
        chk("seq_err_set", seq_err, 1);
        read_collect(0, 0, -1);

        repeat (47) write_frame(0, 0, 0, 0, -1);
        read_collect(0, 1, -1);
        write_frame(0, 0, 1, 0, -1);
        chk("nframes_47", nframes, 47);
        chk("full_after_net0", buf_full, 0);
        write_frame(0, 0, 0, 0, -1);
        chk("full_after_48", buf_full, 1);
        repeat (47) read_collect(0, 0, -1);
        chk("nframes_1", nframes, 1);
        write_frame(0, 0, 0, 1, -1);
        chk("nframes_net0", nframes, 1);
        read_collect(1, 0, -1);
        read_collect(0, 0, -1);
        chk("empty_end", buf_empty, 1);

        write_frame(0, 0, 0, 0, -1);
        write_frame(0, 0, 0, 0, -1);
        read_collect(0, 0, 20);
        write_frame(0, 0, 0, 0, 10);
        write_frame(0, 0, 0, 0, -1);
        read_collect(0, 0, -1);
        chk("empty_final", buf_empty, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/header_buffer_ctrl.md
Name: header_buffer_ctrl

Overview:
Sequencer for the dual-port header block RAM used as a circular event-header buffer.
- Port A (write-only) is fed by the header builder one fixed-length frame at a time.
- Port B (read-only) is drained frame-by-frame on readout request.
- The block owns both address pointers, word occupancy, frame count, overflow detection and the read-latency alignment. The RAM itself stays external.

Parameters:
RAM_WIDTH, 18, data bits per RAM word (passed through to the RAM)
RAM_ADRB, 11, RAM address bits; buffer depth = 2**RAM_ADRB words
HDR_WORDS, 42, words per header frame; must be 2..2**RAM_ADRB

Ports:
clock  in  1  single system clock, all logic rising-edge
global_reset  in  1  asynchronous, active-high reset
wr_start  in  1  pulse: begin a new header frame
wr_en  in  1  header word valid this cycle
wr_data  in  RAM_WIDTH  header word
rd_start  in  1  pulse: request readout of oldest frame
rd_busy  out  1  readout sequence in progress
rd_valid  out  1  rd_data valid
rd_last  out  1  final word of frame on rd_data
rd_data  out  RAM_WIDTH  readout word
ram_wea  out  1  RAM port A write enable
ram_adra  out  RAM_ADRB  RAM port A address
ram_dataa  out  RAM_WIDTH  RAM port A data
ram_enb  out  1  RAM port B read enable
ram_adrb  out  RAM_ADRB  RAM port B address
ram_datab  in  RAM_WIDTH  RAM port B data, valid 1 clock after ram_enb
nframes  out  RAM_ADRB  committed, unclaimed frames
buf_full  out  1  free words < HDR_WORDS
buf_empty  out  1  nframes==0 and rd_busy==0
wr_overflow  out  1  sticky: a frame was refused
seq_err  out  1  sticky: wr_start during fill, or wr_en outside fill

Behaviour:
Reset: async, active-high.
- All outputs 0 except buf_empty=1.
- Pointers, counters and stickies cleared; both FSMs to idle.
- Reset mid-frame discards any partial write and any in-flight read. RAM contents are not cleared.

Occupancy:
- used_words is RAM_ADRB+1 bits. buf_full = (2**RAM_ADRB - used_words) < HDR_WORDS.
- Accepted wr_start adds HDR_WORDS (reservation). Read release subtracts HDR_WORDS.
- If both occur in the same cycle, both apply (net 0).

Write FSM:
- W_IDLE: on wr_start,
  - if !buf_full: go to W_FILL, word count=0.
  - else: set wr_overflow; stay in W_IDLE. Subsequent wr_en is ignored and does not set seq_err until the next wr_start.
- W_FILL: each wr_en drives ram_wea=1, ram_adra=wr_ptr, ram_dataa=wr_data combinationally in the same cycle; wr_ptr increments mod 2**RAM_ADRB (wraps silently).
- On the HDR_WORDS-th wr_en: next cycle nframes increments, FSM returns to W_IDLE.
- Gaps in wr_en are allowed. wr_start in W_FILL sets seq_err and is ignored.
- wr_en in W_IDLE (not following a refusal) sets seq_err and does not write.

Read FSM:
- R_IDLE: rd_start with nframes>0 gives R_READ, rd_busy=1, and nframes decrements (claim). If nframes increments and decrements in the same cycle, the net is 0.
- rd_start with nframes==0, or while rd_busy, is ignored.
- R_READ: for exactly HDR_WORDS consecutive cycles, ram_enb=1 and ram_adrb=rd_ptr, with rd_ptr incrementing mod 2**RAM_ADRB. Then R_DRAIN.
- R_DRAIN: one cycle. used_words is released, then R_IDLE, where rd_busy=0.
- Output alignment: rd_valid = ram_enb delayed 1 clock; rd_data = ram_datab. rd_last is asserted with the HDR_WORDS-th rd_valid.
- rd_start to first rd_valid = 2 clocks. A frame occupies rd_busy for HDR_WORDS+1 cycles.
- Back-to-back frames: next rd_start is accepted on the cycle after rd_busy falls.

Collision safety: port A never addresses reserved-but-unreleased read words, because space is reserved at wr_start and released only after the last read issue.

Test Plan:
- Reset, write 1 frame of 42 words with data=index, rd_start -> 42 rd_valid beats, data 0..41 in order, rd_last on beat 42, first rd_valid 2 clocks after rd_start, buf_empty=1 after.
- Write 48 frames without reading -> nframes=48, buf_full=1 (free=32). 49th wr_start -> wr_overflow=1, no ram_wea, nframes stays 48.
- Drain 48 frames, then write/read 100 more frames -> wr_ptr and rd_ptr wrap past 2047 with data intact; e.g. the frame starting at address 2016 spans 2016..2047,0..9.
- wr_en with 10-cycle gaps inside a frame, plus wr_start mid-frame -> frame still commits after the 42nd wr_en; seq_err=1; contents correct.
- Commit a frame on the same cycle as rd_start for another frame -> nframes unchanged (net 0), both frames read correctly; used_words reserve and release in the same cycle nets 0.
- Assert global_reset asynchronously mid-read (beat 20) and mid-write -> all outputs 0 immediately, buf_empty=1, nframes=0, stickies cleared, next frame written and read at address 0.
